// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the FFT result collector.
//   cplx_t       packed complex word, re in the upper half, im in the lower half
//   cap_state_t  capture state of the buffer currently being filled
//   re()/im()    slice a raw DATA_W word into its signed halves
package fft_pkg;

  localparam int unsigned N_POINTS = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned HALF_W   = 16;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned MAG_W    = 17;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, FILL, DROP} cap_state_t;

  function automatic logic signed [HALF_W-1:0] re(input logic [DATA_W-1:0] w);
    return w[DATA_W-1:HALF_W];
  endfunction

  function automatic logic signed [HALF_W-1:0] im(input logic [DATA_W-1:0] w);
    return w[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/fft_result_collector_if.sv
// fft_result_collector_if: bundles the FFT write stream, the frame output
// handshake and the error/status lines of the collector.
//   master: FFT/downstream side (drives we/address/data_in/done/out_ready)
//   slave : collector side (drives out_valid/out_bin*/frame_count/err_*)
// With FFT_COLLECT_MAG_EN defined, out_mag0..3 are added to the slave outputs.
interface fft_result_collector_if;
  import fft_pkg::*;

  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              done;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_bin0;
  logic [DATA_W-1:0] out_bin1;
  logic [DATA_W-1:0] out_bin2;
  logic [DATA_W-1:0] out_bin3;
  logic [CNT_W-1:0]  frame_count;
  logic              err_addr;
  logic              err_incomplete;
  logic              err_overflow;
`ifdef FFT_COLLECT_MAG_EN
  logic [MAG_W-1:0]  out_mag0;
  logic [MAG_W-1:0]  out_mag1;
  logic [MAG_W-1:0]  out_mag2;
  logic [MAG_W-1:0]  out_mag3;
`endif

  modport master (
    output we, address, data_in, done, out_ready,
    input  out_valid, out_bin0, out_bin1, out_bin2, out_bin3, frame_count,
           err_addr, err_incomplete, err_overflow
`ifdef FFT_COLLECT_MAG_EN
    , input out_mag0, out_mag1, out_mag2, out_mag3
`endif
  );

  modport slave (
    input  we, address, data_in, done, out_ready,
    output out_valid, out_bin0, out_bin1, out_bin2, out_bin3, frame_count,
           err_addr, err_incomplete, err_overflow
`ifdef FFT_COLLECT_MAG_EN
    , output out_mag0, out_mag1, out_mag2, out_mag3
`endif
  );

endinterface

// File: rtl/fft_cplx_abs_sum.sv
// fft_cplx_abs_sum: |re| + |im| of one complex word as an unsigned 17-bit sum.
//   value  in   cplx_t  complex input
//   sum_c  out  17      combinational magnitude estimate (|-32768| = 32768)
// Only built when FFT_COLLECT_MAG_EN is defined.
`ifdef FFT_COLLECT_MAG_EN
module fft_cplx_abs_sum
  import fft_pkg::*;
(
  input  cplx_t            value,
  output logic [MAG_W-1:0] sum_c
);

  logic signed [MAG_W-1:0] re_x;
  logic signed [MAG_W-1:0] im_x;
  logic        [MAG_W-1:0] re_abs;
  logic        [MAG_W-1:0] im_abs;

  // Sign-extend before negating so the most negative value has a representable magnitude.
  always_comb begin
    re_x   = MAG_W'(value.re);
    im_x   = MAG_W'(value.im);
    re_abs = re_x[MAG_W-1] ? MAG_W'(-re_x) : MAG_W'(re_x);
    im_abs = im_x[MAG_W-1] ? MAG_W'(-im_x) : MAG_W'(im_x);
    sum_c  = re_abs + im_abs;
  end

endmodule
`endif

// File: rtl/fft_result_collector.sv
// fft_result_collector: captures the serial 4-bin FFT result write stream into a
// ping-pong buffer pair and offers each completed frame on a valid/ready output.
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high
//   bus    slave modport of fft_result_collector_if:
//          we/address/data_in/done write stream, out_ready/out_valid/out_bin0..3
//          frame handshake, frame_count, err_addr/err_incomplete/err_overflow pulses
// Optional: FFT_COLLECT_MAG_EN adds out_mag0..3 = |re|+|im| of the offered bins.
module fft_result_collector
  import fft_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  fft_result_collector_if.slave bus
);

  cap_state_t           state_q, state_d;
  logic [N_POINTS-1:0]  mask_q, mask_d;
  logic [1:0]           full_q, full_d;
  logic                 fill_sel_q, fill_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_addr_q, err_addr_d;
  logic                 err_inc_q, err_inc_d;
  logic                 err_ovf_q, err_ovf_d;
  cplx_t                buf_q [2][N_POINTS];

  logic                 addr_ok;
  logic                 fill_full;
  logic                 done_edge;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  cplx_t                wr_data;

  assign addr_ok   = (bus.address[ADDR_W-1:IDX_W] == '0);
  assign wr_idx    = bus.address[IDX_W-1:0];
  assign fill_full = full_q[fill_sel_q];
  assign done_edge = bus.done & ~done_q;
  assign wr_data   = '{re: re(bus.data_in), im: im(bus.data_in)};

  // Next-state logic: the write of a cycle lands before any done-edge closure in that cycle.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    rd_sel_d   = rd_sel_q;
    cnt_d      = cnt_q;
    done_d     = bus.done;
    err_addr_d = 1'b0;
    err_inc_d  = 1'b0;
    err_ovf_d  = 1'b0;
    wr_en      = 1'b0;

    if (bus.we) begin
      if (!addr_ok) begin
        err_addr_d = 1'b1;
      end else if (!fill_full) begin
        wr_en          = 1'b1;
        mask_d[wr_idx] = 1'b1;
      end
      if (fill_full) begin
        state_d = DROP;
      end else if (addr_ok && state_q == IDLE) begin
        state_d = FILL;
      end
    end

    // Consume works on rd_sel while a commit only targets a free fill buffer, so both can apply.
    if (bus.out_ready && full_q[rd_sel_q]) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end

    if (done_edge) begin
      if (state_d == DROP || fill_full) begin
        err_ovf_d = 1'b1;
      end else if (&mask_d) begin
        full_d[fill_sel_q] = 1'b1;
        fill_sel_d         = ~fill_sel_q;
        cnt_d              = cnt_q + CNT_W'(1);
      end else begin
        err_inc_d = 1'b1;
      end
      mask_d  = '0;
      state_d = IDLE;
    end
  end

  // State and buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      full_q     <= '0;
      fill_sel_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_addr_q <= 1'b0;
      err_inc_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < N_POINTS; i++) begin
          buf_q[b][i] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      full_q     <= full_d;
      fill_sel_q <= fill_sel_d;
      rd_sel_q   <= rd_sel_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_addr_q <= err_addr_d;
      err_inc_q  <= err_inc_d;
      err_ovf_q  <= err_ovf_d;
      if (wr_en) begin
        buf_q[fill_sel_q][wr_idx] <= wr_data;
      end
    end
  end

  assign bus.out_valid      = full_q[rd_sel_q];
  assign bus.out_bin0       = buf_q[rd_sel_q][0];
  assign bus.out_bin1       = buf_q[rd_sel_q][1];
  assign bus.out_bin2       = buf_q[rd_sel_q][2];
  assign bus.out_bin3       = buf_q[rd_sel_q][3];
  assign bus.frame_count    = cnt_q;
  assign bus.err_addr       = err_addr_q;
  assign bus.err_incomplete = err_inc_q;
  assign bus.err_overflow   = err_ovf_q;

`ifdef FFT_COLLECT_MAG_EN
  logic [MAG_W-1:0] mag [N_POINTS];

  for (genvar g = 0; g < N_POINTS; g++) begin : g_mag
    fft_cplx_abs_sum u_abs (
      .value (buf_q[rd_sel_q][g]),
      .sum_c (mag[g])
    );
  end

  assign bus.out_mag0 = mag[0];
  assign bus.out_mag1 = mag[1];
  assign bus.out_mag2 = mag[2];
  assign bus.out_mag3 = mag[3];
`endif

endmodule

// File: tb/tb_fft_result_collector.sv
// tb_fft_result_collector: scoreboard bench for fft_result_collector.
// The stimulus side keeps a frame-level model (held-frame count, bins written in
// the current frame, drop flag) and pushes expected frames and per-cycle error
// pulses into queues; a negedge monitor pops and compares against the DUT.
// Define FFT_COLLECT_MAG_EN to also check out_mag0..3.
module tb_fft_result_collector;
  import fft_pkg::*;

  typedef logic [3:0][31:0] frame_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_result_collector_if bus();

  fft_result_collector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  frame_t     exp_frames[$];
  logic [2:0] exp_errs[$];   // {err_addr, err_incomplete, err_overflow}

  int          held;
  logic [31:0] mbins [4];
  logic [3:0]  mmask;
  bit          mdrop;
  bit          prev_done;
  logic [15:0] mcount;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mag_of(input logic [31:0] w);
    int r;
    int i;
    r = $signed(w[31:16]);
    i = $signed(w[15:0]);
    if (r < 0) r = -r;
    if (i < 0) i = -i;
    return 32'(r + i);
  endfunction

  // One clock cycle of stimulus plus the model's view of what that cycle does.
  task automatic cyc(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit dn, input bit rdy, input bit rst);
    bit         hs;
    bit         commit;
    bit         full;
    logic [2:0] e;
    frame_t     fr;
    reset         = rst;
    bus.we        = w;
    bus.address   = a;
    bus.data_in   = d;
    bus.done      = dn;
    bus.out_ready = rdy;
    e      = 3'b000;
    hs     = 1'b0;
    commit = 1'b0;
    fr     = '0;
    if (!rst) begin
      full = (held == 2);
      hs   = (held > 0) && rdy;
      if (w) begin
        if (a >= 32'd4) e[2] = 1'b1;
        else if (!full) begin
          mbins[a[1:0]] = d;
          mmask[a[1:0]] = 1'b1;
        end
        if (full) mdrop = 1'b1;
      end
      if (dn && !prev_done) begin
        if (mdrop || full) e[0] = 1'b1;
        else if (mmask == 4'hF) begin
          commit = 1'b1;
          fr = {mbins[3], mbins[2], mbins[1], mbins[0]};
        end else e[1] = 1'b1;
        mmask = 4'h0;
        mdrop = 1'b0;
      end
      prev_done = dn;
    end
    @(posedge clk);
    if (rst) begin
      held      = 0;
      mmask     = 4'h0;
      mdrop     = 1'b0;
      prev_done = 1'b0;
      mcount    = 16'd0;
      exp_frames.delete();
    end else begin
      held = held - int'(hs) + int'(commit);
      if (commit) begin
        exp_frames.push_back(fr);
        mcount = mcount + 16'd1;
      end
    end
    exp_errs.push_back(e);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic write_frame(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3);
    cyc(1'b1, 32'd0, b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd1, b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd2, b2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd3, b3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT outputs with the scoreboard queues away from the rising edge.
  initial begin
    logic [2:0] e;
    frame_t     fr;
    forever begin
      @(negedge clk);
      if (exp_errs.size() > 0) begin
        e = exp_errs.pop_front();
        check("err_addr", 32'(bus.err_addr), 32'(e[2]));
        check("err_incomplete", 32'(bus.err_incomplete), 32'(e[1]));
        check("err_overflow", 32'(bus.err_overflow), 32'(e[0]));
        check("out_valid", 32'(bus.out_valid), 32'(exp_frames.size() > 0));
        check("frame_count", 32'(bus.frame_count), 32'(mcount));
        if (bus.out_valid && exp_frames.size() > 0) begin
          fr = exp_frames[0];
          check("out_bin0", bus.out_bin0, fr[0]);
          check("out_bin1", bus.out_bin1, fr[1]);
          check("out_bin2", bus.out_bin2, fr[2]);
          check("out_bin3", bus.out_bin3, fr[3]);
`ifdef FFT_COLLECT_MAG_EN
          check("out_mag0", 32'(bus.out_mag0), mag_of(fr[0]));
          check("out_mag1", 32'(bus.out_mag1), mag_of(fr[1]));
          check("out_mag2", 32'(bus.out_mag2), mag_of(fr[2]));
          check("out_mag3", 32'(bus.out_mag3), mag_of(fr[3]));
`endif
          if (bus.out_ready) void'(exp_frames.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          rp;
    int          mode;
    int          nx;
    int          dw;
    held      = 0;
    mmask     = 4'h0;
    mdrop     = 1'b0;
    prev_done = 1'b0;
    mcount    = 16'd0;
    for (int i = 0; i < 4; i++) mbins[i] = 32'd0;

    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_bin0", bus.out_bin0, 32'd0);
    check("reset out_bin3", bus.out_bin3, 32'd0);
    check("reset frame_count", 32'(bus.frame_count), 32'd0);

    // Single complete frame, then consumed.
    write_frame(32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008);
    check("t1 valid after done", 32'(bus.out_valid), 32'd1);
    check("t1 bin1", bus.out_bin1, 32'h0003_0004);
    check("t1 count", 32'(bus.frame_count), 32'd1);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t1 valid after ready", 32'(bus.out_valid), 32'd0);

    // Two held frames, third overflows, then both drain in order.
    write_frame(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
    idle(1, 1'b0);
    write_frame(32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);
    idle(1, 1'b0);
    write_frame(32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003);
    check("t2 overflow pulse", 32'(bus.err_overflow), 32'd1);
    idle(1, 1'b0);
    check("t2 overflow one cycle", 32'(bus.err_overflow), 32'd0);
    check("t2 A held", bus.out_bin0, 32'hA000_0000);
    idle(1, 1'b1);
    check("t2 B next", bus.out_bin0, 32'hB000_0000);
    idle(1, 1'b1);
    check("t2 drained", 32'(bus.out_valid), 32'd0);

    // Missing bin 2.
    cyc(1'b1, 32'd0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd3, 32'h4444_4444, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t3 incomplete pulse", 32'(bus.err_incomplete), 32'd1);
    check("t3 no valid", 32'(bus.out_valid), 32'd0);
    check("t3 count", 32'(bus.frame_count), 32'd3);
    idle(1, 1'b0);

    // Illegal address mid-frame.
    cyc(1'b1, 32'd0, 32'h0101_0101, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd1, 32'h0202_0202, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("t4 addr pulse", 32'(bus.err_addr), 32'd1);
    cyc(1'b1, 32'd2, 32'h0303_0303, 1'b0, 1'b0, 1'b0);
    check("t4 addr one cycle", 32'(bus.err_addr), 32'd0);
    cyc(1'b1, 32'd3, 32'h0404_0404, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t4 valid", 32'(bus.out_valid), 32'd1);
    check("t4 bin1 untouched", bus.out_bin1, 32'h0202_0202);
    idle(2, 1'b1);

    // Reset mid-frame discards the partial frame.
    cyc(1'b1, 32'd0, 32'h5555_0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd1, 32'h5555_0001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd2, 32'h5555_0002, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("t5 count cleared", 32'(bus.frame_count), 32'd0);
    cyc(1'b1, 32'd3, 32'h5555_0003, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t5 incomplete pulse", 32'(bus.err_incomplete), 32'd1);
    check("t5 no valid", 32'(bus.out_valid), 32'd0);
    idle(1, 1'b0);

    // Extreme values for the magnitude path.
    write_frame(32'h8000_FFFF, 32'h7FFF_0001, 32'h0000_0000, 32'hFFFF_8000);
`ifdef FFT_COLLECT_MAG_EN
    check("t6 mag0", 32'(bus.out_mag0), 32'd32769);
    check("t6 mag1", 32'(bus.out_mag1), 32'd32768);
`endif
    idle(2, 1'b1);

    // Randomized frames: varied ready pressure, extra/illegal writes, wide done pulses.
    for (int f = 0; f < 300; f++) begin
      rp = $urandom_range(0, 4);
      if ($urandom % 60 == 0) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      mode = $urandom % 4;
      if (mode != 0) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom % 3 == 0) cyc(1'b0, 32'd0, 32'd0, 1'b0, ($urandom % 4) < rp, 1'b0);
          cyc(1'b1, 32'((i + f) % 4), $urandom, 1'b0, ($urandom % 4) < rp, 1'b0);
        end
      end
      nx = (mode == 0) ? $urandom_range(1, 4) : $urandom_range(0, 2);
      for (int i = 0; i < nx; i++) begin
        a = 32'($urandom % 4);
        if ($urandom % 8 == 0) begin
          a = $urandom;
          if (a < 32'd4) a = a + 32'd4;
        end
        cyc(1'b1, a, $urandom, 1'b0, ($urandom % 4) < rp, 1'b0);
      end
      dw = $urandom_range(1, 3);
      for (int i = 0; i < dw; i++) begin
        d = $urandom;
        cyc($urandom % 2 == 0, 32'($urandom % 4), d, 1'b1, ($urandom % 4) < rp, 1'b0);
      end
      idle($urandom_range(1, 2), ($urandom % 4) < rp);
    end

    idle(6, 1'b1);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
